traffic_intersection_model: RTL and testbench



---
 rtl/traffic_intersection_model.sv | 152 +++++++++++++++
 tb/tb_traffic_intersection_model.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_intersection_model.sv
// Closed-loop intersection environment: lane queues, sensors,
// drain on green, and light-legality checkers with sticky flags.
package light_package;
  typedef enum logic [1:0] {red, yellow, green} colors;
endpackage

module traffic_intersection_model
  import light_package::*;
#(
  parameter int QDEPTH  = 15,
  parameter int MAXWAIT = 31,
  parameter int MINYEL  = 2,
  localparam int QW = $clog2(QDEPTH+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    arrive,
  input  colors         e_str_light,
  input  colors         w_str_light,
  input  colors         e_left_light,
  input  colors         w_left_light,
  input  colors         ns_light,
  output logic          e_str_sensor,
  output logic          w_str_sensor,
  output logic          e_left_sensor,
  output logic          w_left_sensor,
  output logic          ns_sensor,
  output logic [QW-1:0] e_str_q,
  output logic [QW-1:0] w_str_q,
  output logic [QW-1:0] e_left_q,
  output logic [QW-1:0] w_left_q,
  output logic [QW-1:0] ns_q,
  output logic [4:0]    depart,
  output logic [4:0]    overflow,
  output logic [4:0]    starve,
  output logic [4:0]    seq_err,
  output logic          conflict,
  output logic [15:0]   conflict_time
);
  localparam int WW = $clog2(MAXWAIT+1);
  localparam int YW = $clog2(MINYEL+1);
  localparam logic [QW-1:0] QFULL = QW'(QDEPTH);
  localparam logic [WW-1:0] WMAX  = WW'(MAXWAIT);
  localparam logic [YW-1:0] YMIN  = YW'(MINYEL);

  colors         light [5];
  colors         prev  [5];
  logic [QW-1:0] q     [5];
  logic [WW-1:0] wcnt  [5];
  logic [WW-1:0] wnxt  [5];
  logic [YW-1:0] ylen  [5];
  logic [4:0]    take;
  logic [4:0]    drop;
  logic [4:0]    act;
  logic          forbid;
  logic [15:0]   cycle_ctr;

  function automatic logic legal(
    input colors         p,
    input colors         c,
    input logic [YW-1:0] yl
  );
    return (p == c)
        || (p == red    && c == green)
        || (p == green  && c == yellow)
        || (p == yellow && c == red && yl >= YMIN);
  endfunction

  always_comb begin
    light[0] = e_str_light;
    light[1] = w_str_light;
    light[2] = e_left_light;
    light[3] = w_left_light;
    light[4] = ns_light;
  end

  always_comb begin
    depart = '0;
    take   = '0;
    drop   = '0;
    act    = '0;
    for (int i = 0; i < 5; i++) begin
      wnxt[i]   = wcnt[i];
      depart[i] = (light[i] == green) && (q[i] != '0);
      drop[i]   = arrive[i] && (q[i] == QFULL) && !depart[i];
      take[i]   = arrive[i] && !drop[i];
      act[i]    = (light[i] != red);
      if (light[i] == green || q[i] == '0)
        wnxt[i] = '0;
      else if (wcnt[i] != WMAX)
        wnxt[i] = wcnt[i] + WW'(1);
    end
    // ns clashes with everyone; the crossing left turns clash with
    // the opposing straight
    forbid = (act[4] && (act[3:0] != '0))
          || (act[0] && act[3])
          || (act[1] && act[2]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        q[i]    <= '0;
        wcnt[i] <= '0;
        ylen[i] <= '0;
        prev[i] <= red;
      end
      overflow      <= '0;
      starve        <= '0;
      seq_err       <= '0;
      conflict      <= 1'b0;
      conflict_time <= '0;
      cycle_ctr     <= '0;
    end else begin
      cycle_ctr <= cycle_ctr + 16'd1;
      if (forbid && !conflict)
        conflict_time <= cycle_ctr;
      if (forbid)
        conflict <= 1'b1;
      for (int i = 0; i < 5; i++) begin
        q[i]    <= q[i] + QW'(take[i]) - QW'(depart[i]);
        wcnt[i] <= wnxt[i];
        prev[i] <= light[i];
        if (drop[i])
          overflow[i] <= 1'b1;
        if (wnxt[i] == WMAX)
          starve[i] <= 1'b1;
        if (!legal(prev[i], light[i], ylen[i]))
          seq_err[i] <= 1'b1;
        if (light[i] != yellow)
          ylen[i] <= '0;
        else if (prev[i] != yellow)
          ylen[i] <= YW'(1);
        else if (ylen[i] != YMIN)
          ylen[i] <= ylen[i] + YW'(1);
      end
    end
  end

  assign e_str_q  = q[0];
  assign w_str_q  = q[1];
  assign e_left_q = q[2];
  assign w_left_q = q[3];
  assign ns_q     = q[4];

  assign e_str_sensor  = (q[0] != '0);
  assign w_str_sensor  = (q[1] != '0);
  assign e_left_sensor = (q[2] != '0);
  assign w_left_sensor = (q[3] != '0);
  assign ns_sensor     = (q[4] != '0);

endmodule

// File: tb/tb_traffic_intersection_model.sv
// Bench for traffic_intersection_model: directed plan plus
// randomized controller-like light phases against a queue model.
module tb_traffic_intersection_model;
  import light_package::*;

  localparam int QDEPTH  = 15;
  localparam int MAXWAIT = 31;
  localparam int MINYEL  = 2;

  logic        clk;
  logic        reset;
  logic [4:0]  arrive;
  colors       lv [5];
  logic        e_str_sensor, w_str_sensor, e_left_sensor;
  logic        w_left_sensor, ns_sensor;
  logic [3:0]  e_str_q, w_str_q, e_left_q, w_left_q, ns_q;
  logic [4:0]  depart, overflow, starve, seq_err;
  logic        conflict;
  logic [15:0] conflict_time;

  traffic_intersection_model dut (
    .clk           (clk),
    .reset         (reset),
    .arrive        (arrive),
    .e_str_light   (lv[0]),
    .w_str_light   (lv[1]),
    .e_left_light  (lv[2]),
    .w_left_light  (lv[3]),
    .ns_light      (lv[4]),
    .e_str_sensor  (e_str_sensor),
    .w_str_sensor  (w_str_sensor),
    .e_left_sensor (e_left_sensor),
    .w_left_sensor (w_left_sensor),
    .ns_sensor     (ns_sensor),
    .e_str_q       (e_str_q),
    .w_str_q       (w_str_q),
    .e_left_q      (e_left_q),
    .w_left_q      (w_left_q),
    .ns_q          (ns_q),
    .depart        (depart),
    .overflow      (overflow),
    .starve        (starve),
    .seq_err       (seq_err),
    .conflict      (conflict),
    .conflict_time (conflict_time)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] dq [5];
  logic [4:0] dsens;
  assign dq[0] = e_str_q;
  assign dq[1] = w_str_q;
  assign dq[2] = e_left_q;
  assign dq[3] = w_left_q;
  assign dq[4] = ns_q;
  assign dsens = {ns_sensor, w_left_sensor, e_left_sensor,
                  w_str_sensor, e_str_sensor};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // staged stimulus, applied on the falling edge
  logic       rst_v;
  logic [4:0] arr_v;
  colors      lvn [5];
  logic [4:0] dep_seen;

  // reference model
  int       mq [5];
  int       mw [5];
  int       myr [5];
  colors    mprev [5];
  bit [4:0] mov, mst, mse;
  bit       mcf;
  int       mct, mctr;
  // allowed[prev][cur]; yellow->red additionally needs a long yellow
  bit       allowed [3][3] = '{'{1, 0, 1},
                               '{1, 1, 0},
                               '{0, 1, 1}};

  task automatic compare();
    bit [4:0] mdep, msens;
    for (int i = 0; i < 5; i++) begin
      mdep[i]  = (lv[i] == green) && (mq[i] > 0);
      msens[i] = (mq[i] != 0);
      chk($sformatf("q%0d", i), dq[i], mq[i]);
    end
    chk("sensor", dsens, msens);
    chk("depart", depart, mdep);
    chk("overflow", overflow, mov);
    chk("starve", starve, mst);
    chk("seq_err", seq_err, mse);
    chk("conflict", conflict, mcf);
    chk("conflict_time", conflict_time, mct);
  endtask

  task automatic model_step();
    bit [4:0] a;
    bit       forb;
    bit       g, d;
    int       nq;
    if (rst_v) begin
      for (int i = 0; i < 5; i++) begin
        mq[i] = 0; mw[i] = 0; myr[i] = 0; mprev[i] = red;
      end
      mov = 0; mst = 0; mse = 0; mcf = 0; mct = 0; mctr = 0;
      return;
    end
    for (int i = 0; i < 5; i++) a[i] = (lv[i] != red);
    forb = (a[4] && a[3:0] != 0) || (a[0] && a[3]) || (a[1] && a[2]);
    if (forb && !mcf) begin
      mcf = 1;
      mct = mctr;
    end
    mctr = (mctr + 1) % 65536;
    for (int i = 0; i < 5; i++) begin
      g = (lv[i] == green);
      d = g && (mq[i] > 0);
      if (g || mq[i] == 0) mw[i] = 0;
      else if (mw[i] < MAXWAIT) mw[i]++;
      if (mw[i] == MAXWAIT) mst[i] = 1;
      nq = mq[i] - int'(d);
      if (arr_v[i]) begin
        if (nq < QDEPTH) nq++;
        else mov[i] = 1;
      end
      mq[i] = nq;
      if (!allowed[int'(mprev[i])][int'(lv[i])]) mse[i] = 1;
      if (mprev[i] == yellow && lv[i] == red && myr[i] < MINYEL)
        mse[i] = 1;
      myr[i] = (lv[i] == yellow) ? myr[i] + 1 : 0;
      mprev[i] = lv[i];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    reset  = rst_v;
    arrive = arr_v;
    for (int i = 0; i < 5; i++) lv[i] = lvn[i];
    #1;
    compare();
    dep_seen = depart;
    model_step();
    @(posedge clk);
  endtask

  task automatic set_all(input colors c);
    for (int i = 0; i < 5; i++) lvn[i] = c;
  endtask

  task automatic idle(input int n);
    arr_v = '0;
    repeat (n) tick();
  endtask

  bit [4:0] pmask [4] = '{5'b00011, 5'b01100, 5'b10000, 5'b00101};

  initial begin
    int depc;
    int ph, stg, rem;
    reset = 1'b1;
    arrive = '0;
    for (int i = 0; i < 5; i++) lv[i] = red;
    rst_v = 1'b1;
    arr_v = '0;
    set_all(red);
    @(posedge clk);
    model_step();
    tick();
    rst_v = 1'b0;
    #1;
    chk("rst_q0", e_str_q, 0);
    chk("rst_sensor", dsens, 0);
    chk("rst_flags", {overflow, starve, seq_err}, 0);

    // arrival, sensor, drain
    arr_v = 5'b00001;
    repeat (3) tick();
    #1;
    chk("plan_q0", e_str_q, 3);
    chk("plan_sens0", e_str_sensor, 1);
    arr_v = '0;
    lvn[0] = green;
    depc = 0;
    repeat (4) begin
      tick();
      depc += int'(dep_seen[0]);
    end
    #1;
    chk("plan_depcnt", depc, 3);
    chk("plan_drained", e_str_q, 0);
    chk("plan_sens_fall", e_str_sensor, 0);
    lvn[0] = yellow;
    idle(2);
    lvn[0] = red;
    idle(1);

    // overflow and starvation on ns
    arr_v = 5'b10000;
    repeat (17) tick();
    #1;
    chk("plan_nsq", ns_q, 15);
    chk("plan_ovf4", overflow[4], 1);
    chk("plan_nostarve", starve[4], 0);
    idle(14);
    #1;
    chk("plan_starve_early", starve[4], 0);
    idle(1);
    #1;
    chk("plan_starve", starve[4], 1);

    // conflict timing
    rst_v = 1'b1;
    idle(1);
    rst_v = 1'b0;
    idle(10);
    lvn[4] = green;
    lvn[0] = yellow;
    idle(1);
    #1;
    chk("plan_conflict", conflict, 1);
    chk("plan_ctime", conflict_time, 10);
    set_all(red);
    idle(9);
    lvn[4] = green;
    lvn[0] = yellow;
    idle(1);
    #1;
    chk("plan_ctime_hold", conflict_time, 10);
    set_all(red);

    // legal left pair and sequences
    rst_v = 1'b1;
    idle(1);
    rst_v = 1'b0;
    lvn[2] = green;
    lvn[3] = green;
    idle(3);
    #1;
    chk("plan_noconflict", conflict, 0);
    lvn[2] = yellow;
    lvn[3] = yellow;
    idle(2);
    lvn[2] = red;
    lvn[3] = red;
    idle(1);
    #1;
    chk("plan_seq_clean", seq_err, 0);
    lvn[0] = green;
    idle(1);
    lvn[0] = yellow;
    idle(1);
    lvn[0] = red;
    idle(1);
    #1;
    chk("plan_short_yel", seq_err[0], 1);
    lvn[3] = green;
    idle(1);
    lvn[3] = red;
    idle(1);
    #1;
    chk("plan_g2r", seq_err[3], 1);

    // full lane with simultaneous arrival and departure
    rst_v = 1'b1;
    idle(1);
    rst_v = 1'b0;
    arr_v = 5'b00100;
    repeat (15) tick();
    lvn[2] = green;
    repeat (3) tick();
    #1;
    chk("plan_full_hold", e_left_q, 15);
    chk("plan_full_noovf", overflow[2], 0);
    lvn[2] = yellow;
    repeat (2) tick();
    #1;
    chk("plan_full_ovf", overflow[2], 1);
    lvn[2] = red;
    idle(1);

    // mid-run reset pulse
    rst_v = 1'b1;
    idle(1);
    rst_v = 1'b0;
    #1;
    chk("mid_rst_q2", e_left_q, 0);
    chk("mid_rst_sens", dsens, 0);
    chk("mid_rst_flags", {overflow, starve, seq_err, 4'b0, conflict}, 0);

    // randomized controller-like phases with rare glitches and resets
    ph = 0;
    stg = 2;
    rem = 0;
    for (int n = 0; n < 3000; n++) begin
      if (rem == 0) begin
        stg = (stg + 1) % 3;
        if (stg == 0) ph = $urandom_range(0, 3);
        rem = (stg == 0) ? $urandom_range(1, 10) :
              (stg == 1) ? $urandom_range(1, 3) : $urandom_range(1, 2);
      end
      rem--;
      for (int i = 0; i < 5; i++)
        lvn[i] = pmask[ph][i] ? ((stg == 0) ? green :
                                 (stg == 1) ? yellow : red) : red;
      if ($urandom_range(0, 149) == 0)
        lvn[$urandom_range(0, 4)] = colors'($urandom_range(0, 2));
      for (int i = 0; i < 5; i++)
        arr_v[i] = ($urandom_range(0, 99) < 35);
      rst_v = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst_v = 1'b0;
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
